// File: rtl/count_down_ticker_pkg.sv
// Shared types and constants for the countdown ticker: FSM states, time triple,
// field limits and the clamp/borrow helpers used by the top level.
package count_down_ticker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [6:0] MAX_MM = 7'd59;
  localparam logic [6:0] MAX_SS = 7'd59;
  localparam logic [6:0] MAX_MS = 7'd99;

  typedef struct packed {
    logic [6:0] mm;
    logic [6:0] ss;
    logic [6:0] ms;
  } hms_t;

  function automatic hms_t clamp_time(logic [6:0] mm, logic [6:0] ss, logic [6:0] ms);
    hms_t r;
    r.mm = (mm > MAX_MM) ? MAX_MM : mm;
    r.ss = (ss > MAX_SS) ? MAX_SS : ss;
    r.ms = (ms > MAX_MS) ? MAX_MS : ms;
    return r;
  endfunction

  // One hundredth down with borrow; a zero count stays at zero.
  function automatic hms_t dec_time(hms_t t);
    hms_t r;
    r = t;
    if (t.ms != 7'd0) begin
      r.ms = t.ms - 7'd1;
    end else if (t.ss != 7'd0) begin
      r.ss = t.ss - 7'd1;
      r.ms = MAX_MS;
    end else if (t.mm != 7'd0) begin
      r.mm = t.mm - 7'd1;
      r.ss = MAX_SS;
      r.ms = MAX_MS;
    end
    return r;
  endfunction

  function automatic logic is_zero(hms_t t);
    return (t.mm == 7'd0) && (t.ss == 7'd0) && (t.ms == 7'd0);
  endfunction

endpackage

// File: rtl/tick_hundredth_en.sv
// Prescaler producing a one-cycle enable every TICK_DIV enabled cycles.
// The count freezes while en is low; clr has priority over en.
module tick_hundredth_en #(
  parameter int TICK_DIV = 20000
) (
  input  logic clk_2MHz,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_2MHz or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/count_down_ticker.sv
// MM:SS:hundredths countdown timer with LOAD > PAUSE > START priority.
// Define COUNTDOWN_AUTORELOAD_EN to reload the last loaded value on expiry instead of stopping.
module count_down_ticker
  import count_down_ticker_pkg::*;
#(
  parameter int TICK_DIV = 20000
) (
  input  logic       clk_2MHz,
  input  logic       reset_n,
  input  logic [6:0] setMM,
  input  logic [6:0] setSS,
  input  logic [6:0] setMS,
  input  logic       LOAD,
  input  logic       START,
  input  logic       PAUSE,
  output logic [6:0] outMM,
  output logic [6:0] outSS,
  output logic [6:0] outMS,
  output logic       running,
  output logic       done,
  output logic       expired
);

  state_e state_q, state_d;
  hms_t   cnt_q, cnt_d;
  hms_t   preset;
  hms_t   dec;
  logic   done_q, done_d;
  logic   pre_en, pre_clr, tick;
`ifdef COUNTDOWN_AUTORELOAD_EN
  hms_t   reload_q, reload_d;
`endif

  assign preset = clamp_time(setMM, setSS, setMS);
  assign dec    = dec_time(cnt_q);
  assign pre_en = (state_q == ST_RUN) && !LOAD && !PAUSE;

  tick_hundredth_en #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk_2MHz (clk_2MHz),
    .reset_n  (reset_n),
    .en       (pre_en),
    .clr      (pre_clr),
    .tick     (tick)
  );

  // Resuming from PAUSED keeps the frozen prescaler phase; starting from IDLE restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pre_clr = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (LOAD) begin
      state_d = ST_IDLE;
      cnt_d   = preset;
      pre_clr = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_d = preset;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!PAUSE && START && !is_zero(cnt_q)) begin
            state_d = ST_RUN;
            pre_clr = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!PAUSE && START && !is_zero(cnt_q)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (PAUSE) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            cnt_d = dec;
            if (is_zero(dec)) begin
              done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              cnt_d   = reload_q;
              pre_clr = 1'b1;
`else
              state_d = ST_EXPIRED;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_2MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNTDOWN_AUTORELOAD_EN
  always_ff @(posedge clk_2MHz or negedge reset_n) begin
    if (!reset_n) reload_q <= '0;
    else          reload_q <= reload_d;
  end
`endif

  assign outMM   = cnt_q.mm;
  assign outSS   = cnt_q.ss;
  assign outMS   = cnt_q.ms;
  assign running = (state_q == ST_RUN);
  assign expired = (state_q == ST_EXPIRED);
  assign done    = done_q;

endmodule

// File: tb/tb_count_down_ticker.sv
// Randomised scoreboard bench for count_down_ticker (TICK_DIV=4); works with or
// without COUNTDOWN_AUTORELOAD_EN, the reference model follows the same macro.
module tb_count_down_ticker;

  localparam int TD = 4;

  typedef struct packed {
    logic [6:0] mm;
    logic [6:0] ss;
    logic [6:0] ms;
    logic       running;
    logic       done;
    logic       expired;
  } obs_t;

  logic       clk_2MHz = 1'b0;
  logic       reset_n  = 1'b1;
  logic [6:0] setMM = '0, setSS = '0, setMS = '0;
  logic       LOAD = 1'b0, START = 1'b0, PAUSE = 1'b0;
  logic [6:0] outMM, outSS, outMS;
  logic       running, done, expired;

  int vectors    = 0;
  int miscompares = 0;
  obs_t sb[$];

  count_down_ticker #(.TICK_DIV(TD)) dut (
    .clk_2MHz (clk_2MHz),
    .reset_n  (reset_n),
    .setMM    (setMM),
    .setSS    (setSS),
    .setMS    (setMS),
    .LOAD     (LOAD),
    .START    (START),
    .PAUSE    (PAUSE),
    .outMM    (outMM),
    .outSS    (outSS),
    .outMS    (outMS),
    .running  (running),
    .done     (done),
    .expired  (expired)
  );

  always #5 clk_2MHz = ~clk_2MHz;

  obs_t got;
  assign got = {outMM, outSS, outMS, running, done, expired};

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t: got %0d:%0d:%0d run=%b done=%b exp=%b, expected %0d:%0d:%0d run=%b done=%b exp=%b",
               name, $time, act.mm, act.ss, act.ms, act.running, act.done, act.expired,
               exp.mm, exp.ss, exp.ms, exp.running, exp.done, exp.expired);
    end
  endtask

  // Reference model: remaining time kept as a plain count of hundredths.
  int remaining = 0;
  int reloadVal = 0;
  int runCycles = 0;
  int mode      = 0;  // 0 idle, 1 run, 2 paused, 3 expired

  function automatic int clampTotal(int mm, int ss, int ms);
    int m, s, h;
    m = (mm > 59) ? 59 : mm;
    s = (ss > 59) ? 59 : ss;
    h = (ms > 99) ? 99 : ms;
    return m * 6000 + s * 100 + h;
  endfunction

  initial begin
    forever begin
      @(posedge clk_2MHz or negedge reset_n);
      if (!reset_n) begin
        remaining = 0;
        reloadVal = 0;
        runCycles = 0;
        mode      = 0;
        sb.delete();
      end else begin
        obs_t e;
        logic pulse;
        pulse = 1'b0;
        if (LOAD) begin
          remaining = clampTotal(int'(setMM), int'(setSS), int'(setMS));
          reloadVal = remaining;
          runCycles = 0;
          mode      = 0;
        end else if (mode == 0 || mode == 2) begin
          if (!PAUSE && START && remaining != 0) begin
            if (mode == 0) runCycles = 0;
            mode = 1;
          end
        end else if (mode == 1) begin
          if (PAUSE) begin
            mode = 2;
          end else begin
            runCycles++;
            if (runCycles == TD) begin
              runCycles = 0;
              remaining--;
              if (remaining == 0) begin
                pulse = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                remaining = reloadVal;
`else
                mode = 3;
`endif
              end
            end
          end
        end
        e.mm      = 7'(remaining / 6000);
        e.ss      = 7'((remaining / 100) % 60);
        e.ms      = 7'(remaining % 100);
        e.running = (mode == 1);
        e.done    = pulse;
        e.expired = (mode == 3);
        sb.push_back(e);
      end
    end
  end

  // Monitor: every falling edge the DUT presents a registered output word.
  initial begin
    forever begin
      @(negedge clk_2MHz);
      if (!reset_n) begin
        checkOutput("reset_state", got, '0);
      end else if (sb.size() != 0) begin
        checkOutput("cycle", got, sb.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic ld, input logic st, input logic ps,
                               input int mm, input int ss, input int ms);
    @(posedge clk_2MHz);
    #1;
    LOAD  = ld;
    START = st;
    PAUSE = ps;
    setMM = 7'(mm);
    setSS = 7'(ss);
    setMS = 7'(ms);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic applyReset();
    @(posedge clk_2MHz);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", got, '0);
    @(negedge clk_2MHz);
    @(negedge clk_2MHz);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #11 reset_n = 1'b1;

    // Three-hundredth countdown to expiry
    applyStimulus(1, 0, 0, 0, 0, 3);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(16);

    // Borrow across minutes, then clamping of an out-of-range preset
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(6);
    applyStimulus(1, 0, 0, 75, 80, 120);
    idleCycles(3);

    // Pause after two run cycles, hold ten, resume
    applyStimulus(1, 0, 0, 0, 0, 5);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(8);

    // LOAD wins over START; START on zero is ignored
    applyStimulus(1, 1, 0, 0, 0, 7);
    idleCycles(3);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(3);

    // Reset between clock edges mid-run
    applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(5);
    applyReset();
    idleCycles(3);

    // Short count: expires, or reloads every 8 cycles with autoreload
    applyStimulus(1, 0, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(26);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int kind, mm, ss, ms;
      logic ld, st, ps;
      kind = int'($urandom_range(0, 3));
      mm = 0; ss = 0; ms = 0;
      if (kind == 1) ms = int'($urandom_range(1, 6));
      else if (kind == 2) begin
        mm = int'($urandom_range(0, 127));
        ss = int'($urandom_range(0, 127));
        ms = int'($urandom_range(0, 127));
      end else if (kind == 3) ss = 1;
      ld = ($urandom_range(0, 29) == 0);
      st = ($urandom_range(0, 4) == 0);
      ps = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) applyReset();
      else applyStimulus(ld, st, ps, mm, ss, ms);
    end

    idleCycles(2);
    @(negedge clk_2MHz);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
